// File: rtl/sprite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_pkg : shared direction encoding, keycodes and edge-mode constants    |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
package sprite_pkg;

   // NONE is only ever held by the pending-key register
   typedef enum logic [2:0] {
      STOPPED = 3'd0,
      LEFT    = 3'd1,
      RIGHT   = 3'd2,
      UP      = 3'd3,
      DOWN    = 3'd4,
      NONE    = 3'd5
   } dir_e;

   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam int EDGE_BOUNCE = 0;
   localparam int EDGE_WRAP   = 1;
   localparam int EDGE_STOP   = 2;

   function automatic dir_e key_to_dir(input logic [7:0] key);
      case (key)
         KEY_A:     return LEFT;
         KEY_D:     return RIGHT;
         KEY_S:     return DOWN;
         KEY_W:     return UP;
         KEY_SPACE: return STOPPED;
         default:   return NONE;
      endcase
   endfunction

   function automatic dir_e reverse_dir(input dir_e d);
      case (d)
         LEFT:    return RIGHT;
         RIGHT:   return LEFT;
         UP:      return DOWN;
         DOWN:    return UP;
         default: return d;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_tick_div : divides enabled frames by FRAME_DIV into a move tick       |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module frame_tick_div #(
   parameter int FRAME_DIV = 1
) (
   input  logic frame_clk,
   input  logic Reset,
   input  logic enable,
   output logic tick
);

   localparam int              c_cw   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(FRAME_DIV - 1);

   logic [c_cw-1:0] r_count;

   assign tick = enable && (r_count == c_last);

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= tick ? '0 : r_count + c_cw'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/sprite_motion.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_motion : keycode-driven per-frame sprite mover with edge handling    |
// | Option        : define SPRITE_ACCEL_EN for held-direction acceleration      |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module sprite_motion
   import sprite_pkg::*;
#(
   parameter int W         = 10,
   parameter int X_CENTER  = 320,
   parameter int Y_CENTER  = 240,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 639,
   parameter int Y_MIN     = 0,
   parameter int Y_MAX     = 479,
   parameter int SIZE      = 4,
   parameter int STEP      = 1,
   parameter int FRAME_DIV = 1,
   parameter int EDGE_MODE = 0,
   parameter int MAX_SPEED = 4
) (
   input  logic         frame_clk,
   input  logic         Reset,
   input  logic [7:0]   keycode,
   input  logic         enable,
   output logic [W-1:0] pos_x,
   output logic [W-1:0] pos_y,
   output logic [W-1:0] size,
   output logic [2:0]   dir,
   output logic         moving,
   output logic         edge_hit
);

   localparam logic signed [W+1:0] c_x_lo = (W+2)'(X_MIN + SIZE);
   localparam logic signed [W+1:0] c_x_hi = (W+2)'(X_MAX - SIZE);
   localparam logic signed [W+1:0] c_y_lo = (W+2)'(Y_MIN + SIZE);
   localparam logic signed [W+1:0] c_y_hi = (W+2)'(Y_MAX - SIZE);
   localparam logic [W+1:0]        c_step = (W+2)'(STEP);

   dir_e                r_dir, r_pending;
   logic [W-1:0]        r_pos_x, r_pos_y;
   logic                r_edge_hit;
   logic                w_tick;

   dir_e                w_key_dir, w_eff, w_new_dir;
   logic                w_on_x, w_neg, w_active, w_lo_hit, w_hi_hit, w_edge;
   logic signed [W+1:0] w_base, w_lo, w_hi, w_cand;
   logic [W+1:0]        w_speed;
   logic [W-1:0]        w_new_pos;

   frame_tick_div #(.FRAME_DIV(FRAME_DIV)) u_tick_div (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .enable    (enable),
      .tick      (w_tick)
   );

   // The key sampled this frame outranks the latched one, so a press moves immediately
   always_comb begin
      w_key_dir = key_to_dir(keycode);
      if (w_key_dir != NONE)      w_eff = w_key_dir;
      else if (r_pending != NONE) w_eff = r_pending;
      else                        w_eff = r_dir;

      w_active = (w_eff != STOPPED);
      w_on_x   = (w_eff == LEFT) || (w_eff == RIGHT);
      w_neg    = (w_eff == LEFT) || (w_eff == UP);
      w_base   = w_on_x ? $signed({2'b00, r_pos_x}) : $signed({2'b00, r_pos_y});
      w_lo     = w_on_x ? c_x_lo : c_y_lo;
      w_hi     = w_on_x ? c_x_hi : c_y_hi;
      w_cand   = w_neg ? (w_base - $signed(w_speed)) : (w_base + $signed(w_speed));
      w_lo_hit = w_active && (w_cand < w_lo);
      w_hi_hit = w_active && (w_cand > w_hi);
      w_edge   = w_lo_hit || w_hi_hit;

      w_new_pos = w_cand[W-1:0];
      w_new_dir = w_eff;
      if (w_edge) begin
         if (EDGE_MODE == EDGE_WRAP) w_new_pos = w_lo_hit ? w_hi[W-1:0] : w_lo[W-1:0];
         else                        w_new_pos = w_lo_hit ? w_lo[W-1:0] : w_hi[W-1:0];
         if (EDGE_MODE == EDGE_BOUNCE)    w_new_dir = reverse_dir(w_eff);
         else if (EDGE_MODE == EDGE_STOP) w_new_dir = STOPPED;
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_pos_x    <= W'(X_CENTER);
         r_pos_y    <= W'(Y_CENTER);
         r_dir      <= STOPPED;
         r_pending  <= NONE;
         r_edge_hit <= 1'b0;
      end else begin
         r_edge_hit <= 1'b0;
         if (w_tick) begin
            r_pending  <= NONE;
            r_dir      <= w_new_dir;
            r_edge_hit <= w_edge;
            if (w_active && w_on_x)  r_pos_x <= w_new_pos;
            if (w_active && !w_on_x) r_pos_y <= w_new_pos;
         end else if (w_key_dir != NONE) begin
            r_pending <= w_key_dir;
         end
      end
   end

`ifdef SPRITE_ACCEL_EN
   localparam logic [W+1:0] c_speed_max = (W+2)'(MAX_SPEED * STEP);
   logic [W+1:0] r_speed, w_speed_up;

   // Holding the current direction (compared with dir after any reversal) speeds up
   assign w_speed_up = ((r_speed + c_step) > c_speed_max) ? c_speed_max : (r_speed + c_step);
   assign w_speed    = (w_eff == r_dir) ? w_speed_up : c_step;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_speed <= c_step;
      end else if (w_tick) begin
         r_speed <= (w_edge || !w_active) ? c_step : w_speed;
      end
   end
`else
   assign w_speed = c_step;
   // MAX_SPEED only shapes the accelerating build
   if (MAX_SPEED < 0) begin : g_max_speed_unused
   end
`endif

   assign pos_x    = r_pos_x;
   assign pos_y    = r_pos_y;
   assign size     = W'(SIZE);
   assign dir      = r_dir;
   assign moving   = (r_dir != STOPPED);
   assign edge_hit = r_edge_hit;

endmodule
`default_nettype wire
